// File: rtl/obstacle_engine.sv
// Obstacle spawner, scroller and hero collision judge for the runner game.
// Two obstacle slots scroll left each enabled tick; first overlap latches game_over.
module obstacle_engine #(
   parameter int unsigned SPAWN_X  = 640,
   parameter int unsigned SPEED    = 2,
   parameter int unsigned HERO_X   = 64,
   parameter int unsigned HERO_W   = 40,
   parameter int unsigned HERO_H   = 32,
   parameter int unsigned OBS_W    = 20,
   parameter int unsigned OBS_H    = 40,
   parameter int unsigned GROUND_Y = 480,
   parameter int unsigned MIN_GAP  = 100
) (
   input  logic        clk_5ms,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        restart,
   input  logic [31:0] y_hero,
   output logic [9:0]  obs0_x,
   output logic [9:0]  obs1_x,
   output logic        obs0_valid,
   output logic        obs1_valid,
   output logic [15:0] score,
   output logic        game_over
);

   typedef enum logic [1:0] {StIdle, StRun, StOver} state_e;

   localparam logic [10:0] HERO_L   = 11'(HERO_X);
   localparam logic [10:0] HERO_R   = 11'(HERO_X + HERO_W);
   localparam logic [10:0] OBS_W11  = 11'(OBS_W);
   localparam logic [9:0]  SPEED10  = 10'(SPEED);
   localparam logic [9:0]  SPAWN10  = 10'(SPAWN_X);
   localparam logic [7:0]  MIN_GAP8 = 8'(MIN_GAP);
   localparam logic [31:0] OBS_TOP  = 32'(GROUND_Y - OBS_H);
   localparam logic [31:0] HERO_H32 = 32'(HERO_H);
   localparam logic [7:0]  LFSR_SEED = 8'hA5;

   state_e            state_q, state_d;
   logic [1:0][9:0]   x_q, x_d;
   logic [1:0]        valid_q, valid_d;
   logic [1:0]        scored_q, scored_d;
   logic [15:0]       score_q, score_d;
   logic [7:0]        gap_q, gap_d;
   logic [7:0]        lfsr_q, lfsr_d;

   logic [1:0]        hit;
   logic              y_overlap;
   logic [1:0]        inc;
   logic [16:0]       score_sum;

   // Vertical overlap is deliberately a 32-bit compare; a wrapped sum means no overlap.
   assign y_overlap = (y_hero + HERO_H32) > OBS_TOP;

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      valid_d   = valid_q;
      scored_d  = scored_q;
      score_d   = score_q;
      gap_d     = gap_q;
      lfsr_d    = lfsr_q;
      hit       = '0;
      inc       = '0;
      score_sum = '0;

      for (int i = 0; i < 2; i++) begin
         hit[i] = valid_q[i] && ({1'b0, x_q[i]} < HERO_R) &&
                  (({1'b0, x_q[i]} + OBS_W11) > HERO_L) && y_overlap;
      end

      unique case (state_q)
         StIdle: begin
            if (enable) begin
               state_d = StRun;
               gap_d   = MIN_GAP8;
            end
         end
         StRun: begin
            if (enable) begin
               lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
               if (|hit) begin
                  state_d = StOver;
               end else begin
                  for (int i = 0; i < 2; i++) begin
                     if (valid_q[i]) begin
                        if (!scored_q[i] && (({1'b0, x_q[i]} + OBS_W11) <= HERO_L)) begin
                           scored_d[i] = 1'b1;
                           inc         = inc + 2'd1;
                        end
                        if (x_q[i] < SPEED10) valid_d[i] = 1'b0;
                        else                  x_d[i]     = x_q[i] - SPEED10;
                     end
                  end
                  score_sum = {1'b0, score_q} + {15'd0, inc};
                  score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];

                  // Spawn sees slots already retired this tick, so the spawn wins.
                  if (gap_q != 8'd0) begin
                     gap_d = gap_q - 8'd1;
                  end else if (!valid_d[0] || !valid_d[1]) begin
                     if (!valid_d[0]) begin
                        x_d[0]      = SPAWN10;
                        valid_d[0]  = 1'b1;
                        scored_d[0] = 1'b0;
                     end else begin
                        x_d[1]      = SPAWN10;
                        valid_d[1]  = 1'b1;
                        scored_d[1] = 1'b0;
                     end
                     gap_d = MIN_GAP8 + {2'b00, lfsr_q[5:0]};
                  end
               end
            end
         end
         StOver: begin
            if (restart) begin
               state_d  = StIdle;
               x_d      = '0;
               valid_d  = '0;
               scored_d = '0;
               score_d  = '0;
               gap_d    = '0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_5ms or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         x_q      <= '0;
         valid_q  <= '0;
         scored_q <= '0;
         score_q  <= '0;
         gap_q    <= '0;
         lfsr_q   <= LFSR_SEED;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         valid_q  <= valid_d;
         scored_q <= scored_d;
         score_q  <= score_d;
         gap_q    <= gap_d;
         lfsr_q   <= lfsr_d;
      end
   end

   assign obs0_x     = x_q[0];
   assign obs1_x     = x_q[1];
   assign obs0_valid = valid_q[0];
   assign obs1_valid = valid_q[1];
   assign score      = score_q;
   assign game_over  = (state_q == StOver);

endmodule

// File: tb/tb_obstacle_engine.sv
// Randomized bench for obstacle_engine: behavioural game model compared every cycle,
// plus directed literal checks of spawn timing, collision, scoring and reset.
module tb_obstacle_engine;

   localparam int SPAWN_X = 640, SPEED = 2, HERO_X = 64, HERO_W = 40, HERO_H = 32;
   localparam int OBS_W = 20, OBS_H = 40, GROUND_Y = 480, MIN_GAP = 100;
   localparam int M_IDLE = 0, M_RUN = 1, M_OVER = 2;

   logic        clk_5ms = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable  = 1'b0;
   logic        restart = 1'b0;
   logic [31:0] y_hero  = 32'd300;
   logic [9:0]  obs0_x, obs1_x;
   logic        obs0_valid, obs1_valid;
   logic [15:0] score;
   logic        game_over;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // Game model
   int         mstate;
   int         mx[2];
   bit         mv[2];
   bit         ms[2];
   int         mscore;
   int         mgap;
   logic [7:0] mlfsr;

   obstacle_engine dut (
      .clk_5ms    (clk_5ms),
      .reset_n    (reset_n),
      .enable     (enable),
      .restart    (restart),
      .y_hero     (y_hero),
      .obs0_x     (obs0_x),
      .obs1_x     (obs1_x),
      .obs0_valid (obs0_valid),
      .obs1_valid (obs1_valid),
      .score      (score),
      .game_over  (game_over)
   );

   always #5 clk_5ms = ~clk_5ms;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mstate = M_IDLE;
      for (int i = 0; i < 2; i++) begin
         mx[i] = 0; mv[i] = 0; ms[i] = 0;
      end
      mscore = 0;
      mgap   = 0;
      mlfsr  = 8'hA5;
   endtask

   task automatic model_step(input bit en, input bit rs, input logic [31:0] y);
      logic [31:0] ysum;
      logic [7:0]  old;
      bit          hit;
      int          slot;
      ysum = y + 32'(HERO_H);
      if (mstate == M_IDLE) begin
         if (en) begin
            mstate = M_RUN;
            mgap   = MIN_GAP;
         end
      end else if (mstate == M_RUN) begin
         if (en) begin
            old   = mlfsr;
            mlfsr = {mlfsr[6:0], mlfsr[7] ^ mlfsr[5] ^ mlfsr[4] ^ mlfsr[3]};
            hit   = 0;
            for (int i = 0; i < 2; i++)
               if (mv[i] && mx[i] < HERO_X + HERO_W && mx[i] + OBS_W > HERO_X &&
                   ysum > 32'(GROUND_Y - OBS_H))
                  hit = 1;
            if (hit) begin
               mstate = M_OVER;
            end else begin
               for (int i = 0; i < 2; i++) begin
                  if (mv[i]) begin
                     if (!ms[i] && mx[i] + OBS_W <= HERO_X) begin
                        ms[i]  = 1;
                        mscore = (mscore == 65535) ? 65535 : mscore + 1;
                     end
                     if (mx[i] < SPEED) mv[i] = 0;
                     else mx[i] = mx[i] - SPEED;
                  end
               end
               if (mgap > 0) begin
                  mgap--;
               end else begin
                  slot = -1;
                  for (int i = 1; i >= 0; i--) if (!mv[i]) slot = i;
                  if (slot >= 0) begin
                     mx[slot] = SPAWN_X; mv[slot] = 1; ms[slot] = 0;
                     mgap = MIN_GAP + int'(old[5:0]);
                  end
               end
            end
         end
      end else begin
         if (rs) begin
            mstate = M_IDLE;
            for (int i = 0; i < 2; i++) begin
               mx[i] = 0; mv[i] = 0; ms[i] = 0;
            end
            mscore = 0;
            mgap   = 0;
         end
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk_5ms) begin
      if (chk_en) begin
         check("obs0_x", 32'(obs0_x), 32'(mx[0]));
         check("obs1_x", 32'(obs1_x), 32'(mx[1]));
         check("obs0_valid", 32'(obs0_valid), 32'(mv[0]));
         check("obs1_valid", 32'(obs1_valid), 32'(mv[1]));
         check("score", 32'(score), 32'(mscore));
         check("game_over", 32'(game_over), 32'(mstate == M_OVER));
      end
   end

   task automatic tick(input bit en, input bit rs, input logic [31:0] y);
      enable  = en;
      restart = rs;
      y_hero  = y;
      @(posedge clk_5ms);
      model_step(en, rs, y);
      #1;
   endtask

   // Called 1 time unit after an edge; reset pulse lies strictly between edges.
   task automatic async_reset(input string tag);
      reset_n = 1'b0;
      #1;
      check({tag, "_rst_obs0_x"}, 32'(obs0_x), 32'd0);
      check({tag, "_rst_obs1_x"}, 32'(obs1_x), 32'd0);
      check({tag, "_rst_valid"}, {30'd0, obs1_valid, obs0_valid}, 32'd0);
      check({tag, "_rst_score"}, 32'(score), 32'd0);
      check({tag, "_rst_game_over"}, 32'(game_over), 32'd0);
      model_reset();
      #1;
      reset_n = 1'b1;
   endtask

   function automatic logic [31:0] rand_y();
      int r;
      r = $urandom_range(0, 99);
      if (r < 90) return 32'd300;
      if (r < 97) return 32'($urandom_range(0, 479));
      return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
   endfunction

   initial begin
      int n;
      model_reset();
      #12;
      check("por_obs0_x", 32'(obs0_x), 32'd0);
      check("por_valid", {30'd0, obs1_valid, obs0_valid}, 32'd0);
      check("por_score", 32'(score), 32'd0);
      check("por_game_over", 32'(game_over), 32'd0);
      reset_n = 1'b1;
      @(posedge clk_5ms);
      #1;
      chk_en = 1'b1;

      // Collision run: hero standing on the ground.
      n = 0;
      do begin tick(1, 0, 32'd448); n++; end while (!obs0_valid && n < 300);
      check("first_spawn_edge", 32'(n), 32'(MIN_GAP + 2));
      check("first_spawn_x", 32'(obs0_x), 32'(SPAWN_X));
      n = 0;
      do begin tick(1, 0, 32'd448); n++; end while (!game_over && n < 400);
      check("hit_seen", 32'(game_over), 32'd1);
      check("hit_x", 32'(obs0_x), 32'd102);
      check("hit_score", 32'(score), 32'd0);
      tick(1, 0, 32'd448);
      check("frozen_x", 32'(obs0_x), 32'd102);

      // Restart, then a clean run with the hero in the air.
      tick(1, 1, 32'd300);
      check("restart_game_over", 32'(game_over), 32'd0);
      check("restart_score", 32'(score), 32'd0);
      check("restart_valid", {30'd0, obs1_valid, obs0_valid}, 32'd0);
      n = 0;
      do begin tick(1, 0, 32'd300); n++; end while (!obs0_valid && n < 300);
      check("restart_spawn_edge", 32'(n), 32'(MIN_GAP + 2));
      repeat (40) tick(1, 0, 32'd300);
      repeat (50) tick(0, 0, 32'd300);
      n = 0;
      do begin tick(1, 0, 32'd300); n++; end while (score == 16'd0 && n < 400);
      check("score_one", 32'(score), 32'd1);
      check("score_edge_x", 32'(obs0_x), 32'd42);
      n = 0;
      do begin tick(1, 0, 32'd300); n++; end while (obs0_x != 10'd0 && n < 100);
      check("reach_zero_x", 32'(obs0_x), 32'd0);
      check("reach_zero_valid", 32'(obs0_valid), 32'd1);
      tick(1, 0, 32'd300);
      check("retire_or_respawn", 32'(!obs0_valid || obs0_x == 10'(SPAWN_X)), 32'd1);

      // Asynchronous reset mid-run; the model then pins the reseeded LFSR via spawn gaps.
      repeat (30) tick(1, 0, 32'd300);
      async_reset("mid");
      repeat (600) tick(1, 0, 32'd300);

      // Randomized play.
      for (int k = 0; k < 20000; k++) begin
         if ($urandom_range(0, 4999) == 0) async_reset("rand");
         tick($urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0, rand_y());
      end

      @(negedge clk_5ms);
      #1;
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
